// File: rtl/chest_est_reader_if.sv
// Output stream from the channel-estimate reader to the equalizer:
// one averaged complex estimate per subcarrier, with a valid/ready handshake.
interface chest_est_reader_if #(
   parameter int WIDTH_R_I = 16,
   parameter int IDX_W     = 4
);
   logic                         out_valid;
   logic                         out_ready;
   logic signed [WIDTH_R_I:0]    out_real;
   logic signed [WIDTH_R_I:0]    out_imag;
   logic        [IDX_W-1:0]      out_idx;

   // Reader side: drives beats, observes acceptance
   modport master (
      output out_valid,
      output out_real,
      output out_imag,
      output out_idx,
      input  out_ready
   );

   // Equalizer side: observes beats, drives acceptance
   modport slave (
      input  out_valid,
      input  out_real,
      input  out_imag,
      input  out_idx,
      output out_ready
   );
endinterface

// File: rtl/chest_est_reader.sv
// Consumer of the NRS LS-estimate store. On start it reads the four stored
// complex estimates, averages them with round-half-up, and streams the single
// averaged estimate once per subcarrier (flat channel across the PRB).
module chest_est_reader #(
   parameter int WIDTH_R_I = 16,
   parameter int N_SC      = 12,
   parameter int IDX_W     = 4
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_start,
   output logic [1:0]                o_rd_addr,
   input  logic signed [WIDTH_R_I:0] i_est_real,
   input  logic signed [WIDTH_R_I:0] i_est_imag,
   output logic                      o_busy,
   output logic                      o_done,
   chest_est_reader_if.master        stream
);

   // Four (WIDTH_R_I+1)-bit values need two guard bits to sum without overflow
   localparam int ACC_W = WIDTH_R_I + 3;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_READ   = 2'd1,
      S_AVG    = 2'd2,
      S_STREAM = 2'd3
   } state_t;

   state_t                    r_state;
   state_t                    w_state_nxt;
   logic [1:0]                r_rd_addr;
   logic [1:0]                w_rd_addr_nxt;
   logic signed [ACC_W-1:0]   r_acc_r;
   logic signed [ACC_W-1:0]   r_acc_i;
   logic signed [ACC_W-1:0]   w_acc_r_nxt;
   logic signed [ACC_W-1:0]   w_acc_i_nxt;
   logic signed [WIDTH_R_I:0] r_out_real;
   logic signed [WIDTH_R_I:0] r_out_imag;
   logic signed [WIDTH_R_I:0] w_out_real_nxt;
   logic signed [WIDTH_R_I:0] w_out_imag_nxt;
   logic [IDX_W-1:0]          r_out_idx;
   logic [IDX_W-1:0]          w_out_idx_nxt;
   logic                      r_valid;
   logic                      w_valid_nxt;
   logic                      r_done;
   logic                      w_done_nxt;
   logic                      r_busy;

   logic signed [ACC_W-1:0]   w_ext_r;
   logic signed [ACC_W-1:0]   w_ext_i;
   logic signed [ACC_W-1:0]   w_sum_r;
   logic signed [ACC_W-1:0]   w_sum_i;
   logic                      w_fire;
   logic                      w_last_idx;

   assign w_ext_r    = {{2{i_est_real[WIDTH_R_I]}}, i_est_real};
   assign w_ext_i    = {{2{i_est_imag[WIDTH_R_I]}}, i_est_imag};
   // Adding 2 before dropping two LSBs rounds the /4 half-up; the dropped
   // bits implement the arithmetic shift and the sum of four always fits
   assign w_sum_r    = r_acc_r + ACC_W'(2);
   assign w_sum_i    = r_acc_i + ACC_W'(2);
   assign w_fire     = r_valid & stream.out_ready;
   assign w_last_idx = (r_out_idx == IDX_W'(N_SC - 1));

   // Next-state and next-output computation for the read/average/stream sequence
   always_comb begin
      w_state_nxt    = r_state;
      w_rd_addr_nxt  = r_rd_addr;
      w_acc_r_nxt    = r_acc_r;
      w_acc_i_nxt    = r_acc_i;
      w_out_real_nxt = r_out_real;
      w_out_imag_nxt = r_out_imag;
      w_out_idx_nxt  = r_out_idx;
      w_valid_nxt    = r_valid;
      w_done_nxt     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               w_state_nxt   = S_READ;
               w_rd_addr_nxt = 2'd0;
               w_acc_r_nxt   = '0;
               w_acc_i_nxt   = '0;
            end else begin
               w_state_nxt   = S_IDLE;
            end
         end
         S_READ: begin
            w_acc_r_nxt   = r_acc_r + w_ext_r;
            w_acc_i_nxt   = r_acc_i + w_ext_i;
            // 2-bit address wraps to 0 after entry 3
            w_rd_addr_nxt = r_rd_addr + 2'd1;
            if (r_rd_addr == 2'd3) begin
               w_state_nxt = S_AVG;
            end else begin
               w_state_nxt = S_READ;
            end
         end
         S_AVG: begin
            w_out_real_nxt = w_sum_r[ACC_W-1:2];
            w_out_imag_nxt = w_sum_i[ACC_W-1:2];
            w_valid_nxt    = 1'b1;
            w_out_idx_nxt  = '0;
            w_state_nxt    = S_STREAM;
         end
         S_STREAM: begin
            if (w_fire && w_last_idx) begin
               w_valid_nxt   = 1'b0;
               w_out_idx_nxt = '0;
               w_done_nxt    = 1'b1;
               w_state_nxt   = S_IDLE;
            end else if (w_fire) begin
               w_out_idx_nxt = r_out_idx + IDX_W'(1);
            end else begin
               w_out_idx_nxt = r_out_idx;
            end
         end
         default: begin
            w_state_nxt   = S_IDLE;
            w_valid_nxt   = 1'b0;
            w_out_idx_nxt = '0;
         end
      endcase
   end

   // State and output registers; reset aborts any run with no done pulse
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= S_IDLE;
         r_rd_addr  <= 2'd0;
         r_acc_r    <= '0;
         r_acc_i    <= '0;
         r_out_real <= '0;
         r_out_imag <= '0;
         r_out_idx  <= '0;
         r_valid    <= 1'b0;
         r_done     <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_rd_addr  <= w_rd_addr_nxt;
         r_acc_r    <= w_acc_r_nxt;
         r_acc_i    <= w_acc_i_nxt;
         r_out_real <= w_out_real_nxt;
         r_out_imag <= w_out_imag_nxt;
         r_out_idx  <= w_out_idx_nxt;
         r_valid    <= w_valid_nxt;
         r_done     <= w_done_nxt;
         r_busy     <= (w_state_nxt != S_IDLE);
      end
   end

   assign o_rd_addr        = r_rd_addr;
   assign o_busy           = r_busy;
   assign o_done           = r_done;
   assign stream.out_valid = r_valid;
   assign stream.out_real  = r_out_real;
   assign stream.out_imag  = r_out_imag;
   assign stream.out_idx   = r_out_idx;

endmodule

// File: tb/tb_chest_est_reader.sv
// Randomized bench for chest_est_reader: a behavioural model computes the
// rounded mean of the four stored estimates and the expected beat sequence.
module tb_chest_est_reader;
   localparam int WIDTH_R_I = 16;
   localparam int N_SC      = 12;
   localparam int IDX_W     = 4;

   logic clk = 1'b0;
   logic rst;
   logic i_start;
   logic [1:0] rd_addr;
   logic signed [WIDTH_R_I:0] est_real;
   logic signed [WIDTH_R_I:0] est_imag;
   logic busy;
   logic done;

   logic signed [WIDTH_R_I:0] mem_r [4];
   logic signed [WIDTH_R_I:0] mem_i [4];

   int  n_vec = 0;
   int  n_err = 0;
   longint exp_r;
   longint exp_i;

   chest_est_reader_if #(.WIDTH_R_I(WIDTH_R_I), .IDX_W(IDX_W)) s ();

   chest_est_reader #(.WIDTH_R_I(WIDTH_R_I), .N_SC(N_SC), .IDX_W(IDX_W)) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_start    (i_start),
      .o_rd_addr  (rd_addr),
      .i_est_real (est_real),
      .i_est_imag (est_imag),
      .o_busy     (busy),
      .o_done     (done),
      .stream     (s.master)
   );

   // Estimate store: combinational read at the requested address
   assign est_real = mem_r[rd_addr];
   assign est_imag = mem_i[rd_addr];

   always #5 clk = ~clk;

   task automatic chk(input string tag, input longint obs, input longint expv);
      n_vec++;
      if (obs !== expv) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
      end
   endtask

   // floor((sum + 2) / 4) with plain integer arithmetic
   function automatic longint rnd_avg(input longint sum);
      longint t;
      t = sum + 2;
      if (t >= 0) return t / 4;
      else        return -((-t + 3) / 4);
   endfunction

   task automatic load_mem(input int r0, input int r1, input int r2, input int r3,
                           input int j0, input int j1, input int j2, input int j3);
      longint sr;
      longint si;
      mem_r[0] = r0[WIDTH_R_I:0]; mem_r[1] = r1[WIDTH_R_I:0];
      mem_r[2] = r2[WIDTH_R_I:0]; mem_r[3] = r3[WIDTH_R_I:0];
      mem_i[0] = j0[WIDTH_R_I:0]; mem_i[1] = j1[WIDTH_R_I:0];
      mem_i[2] = j2[WIDTH_R_I:0]; mem_i[3] = j3[WIDTH_R_I:0];
      sr = r0 + r1 + r2 + r3;
      si = j0 + j1 + j2 + j3;
      exp_r = rnd_avg(sr);
      exp_i = rnd_avg(si);
   endtask

   function automatic int rnd17();
      return int'($urandom_range(0, 131071)) - 65536;
   endfunction

   task automatic load_random();
      load_mem(rnd17(), rnd17(), rnd17(), rnd17(), rnd17(), rnd17(), rnd17(), rnd17());
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_rd_addr"}, rd_addr, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_valid"}, s.out_valid, 0);
      chk({tag, "_real"}, s.out_real, 0);
      chk({tag, "_imag"}, s.out_imag, 0);
      chk({tag, "_idx"}, s.out_idx, 0);
      chk({tag, "_done"}, done, 0);
   endtask

   task automatic issue_start();
      i_start = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
      chk("busy_after_start", busy, 1);
      chk("valid_after_start", s.out_valid, 0);
   endtask

   // Called #1 after the edge that accepted start.
   // mode 0: ready always, 1: random ready, 2: ready pattern 1,0,0
   task automatic run_body(input int mode, input bit inject, input bit chain, input int abort_beat);
      int beats = 0;
      int cyc   = 0;
      bit fin   = 1'b0;
      bit seen  = 1'b0;
      bit rdy;
      bit fire;
      while (!fin && cyc < 200) begin
         if (s.out_valid) begin
            if (!seen) begin
               chk("first_valid_latency", cyc, 5);
               seen = 1'b1;
            end
            chk("out_real", s.out_real, exp_r);
            chk("out_imag", s.out_imag, exp_i);
            chk("out_idx", s.out_idx, beats);
         end
         if (done) begin
            fin = 1'b1;
            chk("beats_at_done", beats, N_SC);
            chk("valid_at_done", s.out_valid, 0);
            chk("busy_at_done", busy, 0);
            chk("idx_at_done", s.out_idx, 0);
         end else begin
            chk("busy_in_run", busy, 1);
         end
         if (!fin) begin
            if (abort_beat >= 0 && beats == abort_beat && s.out_valid) begin
               rst = 1'b1;
               s.out_ready = 1'b1;
               @(posedge clk); #1;
               rst = 1'b0;
               check_all_zero("after_abort");
               for (int k = 0; k < 3; k++) begin
                  @(posedge clk); #1;
                  chk("no_done_after_abort", done, 0);
                  chk("idle_after_abort", busy, 0);
               end
               return;
            end
            case (mode)
               0:       rdy = 1'b1;
               1:       rdy = $urandom_range(0, 1) == 1;
               default: rdy = (cyc % 3) == 0;
            endcase
            s.out_ready = rdy;
            fire = s.out_valid && rdy;
            i_start = inject && (cyc == 1 || cyc == 8);
            @(posedge clk); #1;
            cyc++;
            i_start = 1'b0;
            if (fire) beats++;
         end
      end
      chk("run_completed", fin, 1);
      if (chain) begin
         load_random();
         issue_start();
      end else begin
         s.out_ready = ($urandom_range(0, 1) == 1);
         @(posedge clk); #1;
         chk("done_single_pulse", done, 0);
         chk("no_queued_start", busy, 0);
      end
   endtask

   initial begin
      rst = 1'b1;
      i_start = 1'b0;
      s.out_ready = 1'b0;
      load_mem(0, 0, 0, 0, 0, 0, 0, 0);
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      // T1 constant entries
      load_mem(100, 100, 100, 100, -40, -40, -40, -40);
      issue_start();
      run_body(0, 1'b0, 1'b0, -1);

      // T2 rounding in both directions
      load_mem(1, 2, 3, 4, -1, -2, -3, -4);
      issue_start();
      run_body(0, 1'b0, 1'b0, -1);

      // T3 extremes
      load_mem(-65536, -65536, -65536, -65536, 65535, 65535, 65535, 65535);
      issue_start();
      run_body(1, 1'b0, 1'b0, -1);
      load_mem(65535, 65535, 65535, 65535, -65536, -65536, -65536, -65536);
      issue_start();
      run_body(0, 1'b0, 1'b0, -1);

      // T4 backpressure pattern
      load_random();
      issue_start();
      run_body(2, 1'b0, 1'b0, -1);

      // T5 stray starts ignored, then start on the done cycle
      load_random();
      issue_start();
      run_body(1, 1'b1, 1'b1, -1);
      run_body(0, 1'b0, 1'b0, -1);

      // T6 reset mid-stream, then a full run
      load_random();
      issue_start();
      run_body(0, 1'b0, 1'b0, 5);
      load_random();
      issue_start();
      run_body(0, 1'b0, 1'b0, -1);

      // Random runs
      for (int n = 0; n < 8; n++) begin
         load_random();
         issue_start();
         run_body(int'($urandom_range(0, 2)), ($urandom_range(0, 1) == 1), 1'b0, -1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
